// File: rtl/risc_pkg.sv
// Package: risc_pkg
// Purpose: Shared constants for the 8-bit RISC MCU. It holds the opcode
//          values, the FSM state encoding and the bus-select codes. The
//          control unit, the ALU and the datapath top all use it.
package risc_pkg;

   localparam int DATA_SIZE = 8;
   localparam int OP_SIZE   = 4;

   // Opcodes. STORE, LOAD and HALT each occupy a range of codes.
   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_NOT   = 4'd4;
   localparam logic [3:0] OP_NOP   = 4'd5;
   localparam logic [3:0] OP_JMP   = 4'd6;
   localparam logic [3:0] OP_BRZ   = 4'd7;
   localparam logic [3:0] OP_STO0  = 4'd8;
   localparam logic [3:0] OP_STO1  = 4'd9;
   localparam logic [3:0] OP_LD0   = 4'd10;
   localparam logic [3:0] OP_LD1   = 4'd11;

   // Bus_1 source codes. Values 0..3 select R0..R3 directly.
   localparam logic [2:0] BUS1_PC   = 3'd4;

   // Bus_2 source codes
   localparam logic [1:0] BUS2_ALU  = 2'd0;
   localparam logic [1:0] BUS2_BUS1 = 2'd1;
   localparam logic [1:0] BUS2_MEM  = 2'd2;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_FET1 = 4'd1,
      S_FET2 = 4'd2,
      S_DEC  = 4'd3,
      S_EX1  = 4'd4,
      S_RD1  = 4'd5,
      S_RD2  = 4'd6,
      S_WR1  = 4'd7,
      S_WR2  = 4'd8,
      S_BR1  = 4'd9,
      S_BR2  = 4'd10,
      S_HALT = 4'd11
   } state_t;

   function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/control_unit_risc.sv
// Module: control_unit_risc
// Purpose: Multi-cycle fetch/decode/execute sequencer for the 8-bit RISC MCU.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   instruction   IR contents {opcode[7:4], src[3:2], dest[1:0]}
//   zero          registered zero flag (Reg_Z)
//   load_reg      one-hot load enable for R0..R3
//   load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z
//                 load enables for the datapath registers
//   sel_bus_1     0..3 = R0..R3, 4 = PC
//   sel_bus_2     0 = ALU, 1 = Bus_1, 2 = memory
//   alu_sel       ALU opcode
//   write         memory write strobe
//   halted        high while the FSM is in S_HALT
module control_unit_risc
   import risc_pkg::*;
#(
   parameter int data_size = 8,
   parameter int op_size   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [data_size-1:0] instruction,
   input  logic                 zero,
   output logic [3:0]           load_reg,
   output logic                 load_pc,
   output logic                 inc_pc,
   output logic                 load_ir,
   output logic                 load_add_r,
   output logic                 load_reg_y,
   output logic                 load_reg_z,
   output logic [2:0]           sel_bus_1,
   output logic [1:0]           sel_bus_2,
   output logic [op_size-1:0]   alu_sel,
   output logic                 write,
   output logic                 halted
);

   state_t               r_state;
   state_t               w_next;
   logic [op_size-1:0]   w_op;
   logic [1:0]           w_src;
   logic [1:0]           w_dest;

   assign w_op   = instruction[data_size-1 -: op_size];
   assign w_src  = instruction[3:2];
   assign w_dest = instruction[1:0];

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      load_reg   = 4'b0000;
      load_pc    = 1'b0;
      inc_pc     = 1'b0;
      load_ir    = 1'b0;
      load_add_r = 1'b0;
      load_reg_y = 1'b0;
      load_reg_z = 1'b0;
      sel_bus_1  = 3'd0;
      sel_bus_2  = 2'd0;
      alu_sel    = '0;
      write      = 1'b0;
      halted     = 1'b0;

      case (r_state)
         S_IDLE: w_next = S_FET1;

         S_FET1: begin
            sel_bus_1  = BUS1_PC;
            sel_bus_2  = BUS2_BUS1;
            load_add_r = 1'b1;
            w_next     = S_FET2;
         end

         S_FET2: begin
            sel_bus_2 = BUS2_MEM;
            load_ir   = 1'b1;
            inc_pc    = 1'b1;
            w_next    = S_DEC;
         end

         S_DEC: begin
            w_next = S_FET1;
            case (w_op)
               OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                  // Latch src into Reg_Y; the ALU sees dest on Bus_1 next cycle.
                  sel_bus_1  = {1'b0, w_src};
                  sel_bus_2  = BUS2_BUS1;
                  load_reg_y = 1'b1;
                  w_next     = S_EX1;
               end
               OP_NOT: begin
                  sel_bus_1  = {1'b0, w_src};
                  alu_sel    = OP_NOT;
                  sel_bus_2  = BUS2_ALU;
                  load_reg   = reg_onehot(w_dest);
                  load_reg_z = 1'b1;
               end
               OP_NOP: w_next = S_FET1;
               OP_BRZ, OP_JMP: begin
                  if (w_op == OP_JMP || zero) begin
                     sel_bus_1  = BUS1_PC;
                     sel_bus_2  = BUS2_BUS1;
                     load_add_r = 1'b1;
                     w_next     = S_BR1;
                  end else begin
                     // Branch not taken: step over the address byte.
                     inc_pc = 1'b1;
                  end
               end
               OP_STO0, OP_STO1, OP_LD0, OP_LD1: begin
                  sel_bus_1  = BUS1_PC;
                  sel_bus_2  = BUS2_BUS1;
                  load_add_r = 1'b1;
                  w_next     = (w_op == OP_STO0 || w_op == OP_STO1) ? S_WR1 : S_RD1;
               end
               default: w_next = S_HALT;
            endcase
         end

         S_EX1: begin
            sel_bus_1  = {1'b0, w_dest};
            alu_sel    = w_op;
            sel_bus_2  = BUS2_ALU;
            load_reg   = reg_onehot(w_dest);
            load_reg_z = 1'b1;
            w_next     = S_FET1;
         end

         S_RD1, S_WR1, S_BR1: begin
            // Operand address byte goes into ADD_R. PC skips it unless a branch reloads PC.
            sel_bus_2  = BUS2_MEM;
            load_add_r = 1'b1;
            inc_pc     = (r_state != S_BR1);
            w_next     = (r_state == S_RD1) ? S_RD2 :
                         (r_state == S_WR1) ? S_WR2 : S_BR2;
         end

         S_RD2: begin
            sel_bus_2 = BUS2_MEM;
            load_reg  = reg_onehot(w_dest);
            w_next    = S_FET1;
         end

         S_WR2: begin
            sel_bus_1 = {1'b0, w_src};
            write     = 1'b1;
            w_next    = S_FET1;
         end

         S_BR2: begin
            sel_bus_2 = BUS2_MEM;
            load_pc   = 1'b1;
            w_next    = S_FET1;
         end

         S_HALT: begin
            halted = 1'b1;
            w_next = S_HALT;
         end

         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_control_unit_risc.sv
module tb_control_unit_risc;

   typedef struct packed {
      logic [3:0] lr;
      logic       lpc, inc, lir, ladd, ly, lz;
      logic [2:0] s1;
      logic [1:0] s2;
      logic [3:0] alu;
      logic       wr, h;
   } ov_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] instruction = 8'h00;
   logic       zero = 1'b0;
   logic [3:0] load_reg;
   logic       load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z;
   logic [2:0] sel_bus_1;
   logic [1:0] sel_bus_2;
   logic [3:0] alu_sel;
   logic       write, halted;

   int total = 0;
   int bad   = 0;
   ov_t exp_q[$];

   always #5 clk = ~clk;

   control_unit_risc dut (
      .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
      .load_reg(load_reg), .load_pc(load_pc), .inc_pc(inc_pc), .load_ir(load_ir),
      .load_add_r(load_add_r), .load_reg_y(load_reg_y), .load_reg_z(load_reg_z),
      .sel_bus_1(sel_bus_1), .sel_bus_2(sel_bus_2), .alu_sel(alu_sel),
      .write(write), .halted(halted)
   );

   ov_t act;
   assign act = '{lr: load_reg, lpc: load_pc, inc: inc_pc, lir: load_ir, ladd: load_add_r,
                  ly: load_reg_y, lz: load_reg_z, s1: sel_bus_1, s2: sel_bus_2,
                  alu: alu_sel, wr: write, h: halted};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input ov_t e);
      total++;
      assert (act === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, act, e);
      end
   endtask

   // Cycle-by-cycle control word each instruction class is supposed to produce,
   // starting at the first fetch cycle.
   task automatic build_seq(input logic [7:0] ins, input logic z);
      ov_t v;
      int op, src, dst;
      op  = int'(ins[7:4]);
      src = int'(ins[3:2]);
      dst = int'(ins[1:0]);
      exp_q.delete();
      v = '0; v.s1 = 3'd4; v.s2 = 2'd1; v.ladd = 1'b1; exp_q.push_back(v);   // fetch address
      v = '0; v.s2 = 2'd2; v.lir = 1'b1; v.inc = 1'b1; exp_q.push_back(v);   // fetch opcode
      if (op <= 3) begin
         v = '0; v.s1 = 3'(src); v.s2 = 2'd1; v.ly = 1'b1; exp_q.push_back(v);
         v = '0; v.s1 = 3'(dst); v.alu = 4'(op); v.lr = 4'(1 << dst); v.lz = 1'b1;
         exp_q.push_back(v);
      end else if (op == 4) begin
         v = '0; v.s1 = 3'(src); v.alu = 4'd4; v.lr = 4'(1 << dst); v.lz = 1'b1;
         exp_q.push_back(v);
      end else if (op == 5 || op >= 12) begin
         exp_q.push_back('0);
      end else if (op == 7 && !z) begin
         v = '0; v.inc = 1'b1; exp_q.push_back(v);
      end else begin
         v = '0; v.s1 = 3'd4; v.s2 = 2'd1; v.ladd = 1'b1; exp_q.push_back(v);
         v = '0; v.s2 = 2'd2; v.ladd = 1'b1; v.inc = (op >= 8); exp_q.push_back(v);
         v = '0;
         if (op == 8 || op == 9) begin
            v.s1 = 3'(src); v.wr = 1'b1;
         end else if (op >= 10) begin
            v.s2 = 2'd2; v.lr = 4'(1 << dst);
         end else begin
            v.s2 = 2'd2; v.lpc = 1'b1;
         end
         exp_q.push_back(v);
      end
   endtask

   // Starts in the first fetch cycle; leaves the FSM one clock past the last
   // checked cycle. nsteps=0 runs the whole instruction.
   task automatic run_instr(input string tag, input logic [7:0] ins, input logic z,
                            input int nsteps);
      int n;
      build_seq(ins, z);
      n = (nsteps == 0) ? exp_q.size() : nsteps;
      for (int i = 0; i < n; i++) begin
         // The IR is not meaningful before decode, so scramble it there.
         instruction = (i < 2) ? 8'($urandom) : ins;
         zero = z;
         #1;
         check($sformatf("%s[%0d]", tag, i), exp_q[i]);
         tick();
      end
   endtask

   initial begin
      ov_t v;
      logic [7:0] ri;
      rst = 1'b1;
      tick();
      tick();
      check("reset_idle", '0);
      rst = 1'b0;
      tick();
      v = '0; v.s1 = 3'd4; v.s2 = 2'd1; v.ladd = 1'b1;
      check("first_fetch", v);

      // Directed: SUB R2,R3, BRZ both ways, STORE from R1
      run_instr("sub", 8'h1B, 1'b0, 0);
      run_instr("brz_nt", 8'h70, 1'b0, 0);
      run_instr("brz_t", 8'h70, 1'b1, 0);
      run_instr("store", 8'h84, 1'b0, 0);

      // Random non-halting instructions back to back
      for (int k = 0; k < 60; k++) begin
         ri = 8'($urandom);
         if (ri[7:6] == 2'b11) ri[7] = 1'b0;
         run_instr($sformatf("rnd_%h", ri), ri, 1'($urandom), 0);
      end

      // LOAD aborted by reset in the operand-read cycle
      run_instr("load_abort", 8'hA2, 1'b0, 3);
      v = '0; v.s2 = 2'd2; v.ladd = 1'b1; v.inc = 1'b1;
      check("load_rd1", v);
      rst = 1'b1;
      tick();
      check("abort_idle", '0);
      rst = 1'b0;
      instruction = 8'h50;
      tick();
      run_instr("nop_after_abort", 8'h50, 1'b0, 0);

      // HALT holds until reset
      run_instr("halt", 8'hC0, 1'b0, 0);
      v = '0; v.h = 1'b1;
      for (int k = 0; k < 20; k++) begin
         instruction = 8'($urandom);
         zero = 1'($urandom);
         #1;
         check($sformatf("halt_hold[%0d]", k), v);
         tick();
      end
      rst = 1'b1;
      tick();
      check("halt_reset", '0);
      rst = 1'b0;
      tick();
      run_instr("post_halt_add", 8'h06, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
